// File: rtl/ga_pkg.sv
// ga_pkg: shared constants and types for the Gate Array sync/interrupt stage.
package ga_pkg;

    // Interrupt line counter: wraps every 52 HSYNCs (300 Hz at 50 Hz frames).
    localparam logic [5:0] R52_WRAP        = 6'd52;
    // A VSYNC-driven counter reset only raises INT if the counter got this far.
    localparam logic [5:0] R52_IRQ_THRESH  = 6'd32;
    // Number of HSYNC falls after VSYNC rise before the counter is reset.
    localparam logic [1:0] VSYNC_IRQ_DELAY = 2'd2;

    // Monitor HSYNC window, in characters since CRTC HSYNC start.
    localparam logic [3:0] MON_HS_START    = 4'd2;
    localparam logic [3:0] MON_HS_END      = 4'd5;

    // Monitor VSYNC window, in lines since CRTC VSYNC start.
    localparam logic [4:0] MON_VS_START    = 5'd2;
    localparam logic [4:0] MON_VS_END      = 5'd5;

    // Length of the vertical blank, in lines.
    localparam logic [4:0] VBLANK_LINES    = 5'd26;

    typedef logic [1:0] ga_mode_t;

endpackage

// File: rtl/ga_edge_det.sv
// ga_edge_det: registers one input every CLOCK and flags its rising and
// falling edges as single-CLOCK pulses (current vs. registered value).
module ga_edge_det (
    input  logic CLOCK,
    input  logic nRESET,
    input  logic D,
    output logic RISE,
    output logic FALL
);

    logic d_q;

    // Previous-cycle copy of the input; no CLKEN gating.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) d_q <= 1'b0;
        else         d_q <= D;
    end

    assign RISE = D & ~d_q;
    assign FALL = ~D & d_q;

endmodule

// File: rtl/ga_sync_irq.sv
// ga_sync_irq: Gate Array sync and interrupt stage behind the CRTC.
// Produces the 52-line Z80 interrupt, monitor HSYNC/VSYNC, the 26-line
// vertical blank and the HSYNC-latched screen mode.
// Optional: define GA_CSYNC_EN to build the registered composite sync;
// otherwise CSYNC is tied low.
module ga_sync_irq
    import ga_pkg::*;
(
    input  logic     CLOCK,
    input  logic     nRESET,
    input  logic     CLKEN,
    input  logic     HSYNC_IN,
    input  logic     VSYNC_IN,
    input  logic     IRQ_ACK,
    input  logic     R52_CLR,
    input  logic     MODE_WR,
    input  ga_mode_t MODE_DI,
    output logic     INT_N,
    output logic     MON_HSYNC,
    output logic     MON_VSYNC,
    output logic     VBLANK,
    output ga_mode_t MODE,
    output logic     CSYNC
);

    logic hs_rise, hs_fall, vs_rise;
    logic vs_fall_unused;  // VSYNC end carries no meaning for this stage

    ga_edge_det u_hs_edge (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .D      (HSYNC_IN),
        .RISE   (hs_rise),
        .FALL   (hs_fall)
    );

    ga_edge_det u_vs_edge (
        .CLOCK  (CLOCK),
        .nRESET (nRESET),
        .D      (VSYNC_IN),
        .RISE   (vs_rise),
        .FALL   (vs_fall_unused)
    );

    // ------------------------------------------------------------------
    // VSYNC delay: armed by vs_rise, counts HSYNC falls, fires on the 2nd.
    // ------------------------------------------------------------------
    logic       vs_armed;
    logic [1:0] vs_dly;
    logic       vs_irq_evt;

    // A vs_rise in the same cycle as an hs_fall re-arms and wins.
    assign vs_irq_evt = vs_armed && hs_fall && !vs_rise &&
                        (vs_dly == VSYNC_IRQ_DELAY - 2'd1);

    // Arm on VSYNC rise, count HSYNC falls, disarm once the reset fires.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            vs_armed <= 1'b0;
            vs_dly   <= 2'd0;
        end else if (vs_rise) begin
            vs_armed <= 1'b1;
            vs_dly   <= 2'd0;
        end else if (vs_irq_evt) begin
            vs_armed <= 1'b0;
            vs_dly   <= 2'd0;
        end else if (vs_armed && hs_fall) begin
            vs_dly   <= vs_dly + 2'd1;
        end
    end

    // ------------------------------------------------------------------
    // Interrupt line counter and INT_N.
    // ------------------------------------------------------------------
    logic [5:0] r52, r52_n;
    logic       int_n_n;
    logic       int_req;

    // Prioritised counter update; a fresh request overrides an acknowledge.
    always_comb begin
        r52_n   = r52;
        int_n_n = INT_N;
        int_req = 1'b0;
        if (R52_CLR) begin
            r52_n   = '0;
            int_n_n = 1'b1;
        end else if (vs_irq_evt) begin
            r52_n = '0;
            if (r52 >= R52_IRQ_THRESH) begin
                int_n_n = 1'b0;
                int_req = 1'b1;
            end
        end else if (hs_fall) begin
            if (r52 == R52_WRAP - 6'd1) begin
                r52_n   = '0;
                int_n_n = 1'b0;
                int_req = 1'b1;
            end else begin
                r52_n = r52 + 6'd1;
            end
        end
        // Acknowledge pulls the counter back below 32 so the next
        // interrupt is never closer than 20 lines.
        if (IRQ_ACK && !int_req) begin
            int_n_n  = 1'b1;
            r52_n[5] = 1'b0;
        end
    end

    // Interrupt state register; ACK/CLR act regardless of CLKEN.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            r52   <= '0;
            INT_N <= 1'b1;
        end else begin
            r52   <= r52_n;
            INT_N <= int_n_n;
        end
    end

    // ------------------------------------------------------------------
    // Monitor HSYNC: characters 2..5 of the CRTC HSYNC, truncated by its end.
    // ------------------------------------------------------------------
    logic [3:0] hcnt;

    // Character counter (saturating) and window decode from its current value.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            hcnt      <= 4'd0;
            MON_HSYNC <= 1'b0;
        end else begin
            MON_HSYNC <= HSYNC_IN && (hcnt >= MON_HS_START) &&
                         (hcnt <= MON_HS_END);
            if (!HSYNC_IN)
                hcnt <= 4'd0;
            else if (CLKEN && (hcnt != 4'hF))
                hcnt <= hcnt + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Vertical blank and monitor VSYNC, counted in HSYNC falls.
    // ------------------------------------------------------------------
    logic [4:0] vcnt, vcnt_n;
    logic       vblank_n;
    logic       mon_vs_n;

    // Line counter runs only inside the blank; vs_rise always restarts it.
    always_comb begin
        vcnt_n   = vcnt;
        vblank_n = VBLANK;
        if (vs_rise) begin
            vcnt_n   = 5'd0;
            vblank_n = 1'b1;
        end else if (VBLANK && hs_fall) begin
            vcnt_n = vcnt + 5'd1;
            if (vcnt_n == VBLANK_LINES)
                vblank_n = 1'b0;
        end
        mon_vs_n = vblank_n && (vcnt_n >= MON_VS_START) && (vcnt_n <= MON_VS_END);
    end

    // Vertical state register; MON_VSYNC stays aligned with VBLANK/vcnt.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            vcnt      <= 5'd0;
            VBLANK    <= 1'b0;
            MON_VSYNC <= 1'b0;
        end else begin
            vcnt      <= vcnt_n;
            VBLANK    <= vblank_n;
            MON_VSYNC <= mon_vs_n;
        end
    end

    // ------------------------------------------------------------------
    // Screen mode: written any time, takes effect at the next HSYNC start.
    // ------------------------------------------------------------------
    ga_mode_t mode_pend;

    // Pending mode capture and HSYNC-start transfer (new write wins).
    always_ff @(posedge CLOCK) begin
        if (!nRESET) begin
            mode_pend <= '0;
            MODE      <= '0;
        end else begin
            if (MODE_WR)
                mode_pend <= MODE_DI;
            if (hs_rise)
                MODE <= MODE_WR ? MODE_DI : mode_pend;
        end
    end

    // ------------------------------------------------------------------
    // Composite sync.
    // ------------------------------------------------------------------
`ifdef GA_CSYNC_EN
    // XOR of the monitor syncs, one CLOCK behind them.
    always_ff @(posedge CLOCK) begin
        if (!nRESET) CSYNC <= 1'b0;
        else         CSYNC <= MON_HSYNC ^ MON_VSYNC;
    end
`else
    assign CSYNC = 1'b0;
`endif

endmodule
